// File: rtl/histogram_object_locator.sv
// Scans a finished frame's X/Y projection histograms, extracts the occupied-span
// bounding box and peak bin per axis, clears the histogram and strobes the result.
module histogram_object_locator #(
  parameter int NUM_BINS  = 256,
  parameter int COUNT_W   = 8,
  parameter int THRESHOLD = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               ready,
  output logic               readHistogram,
  input  logic [COUNT_W-1:0] xHistogramOut,
  input  logic [COUNT_W-1:0] yHistogramOut,
  input  logic               xValid,
  input  logic               yValid,
  output logic               clearHistogram,
  input  logic               histogramClear,
  output logic [7:0]         xMin,
  output logic [7:0]         xMax,
  output logic [7:0]         yMin,
  output logic [7:0]         yMax,
  output logic [7:0]         xPeak,
  output logic [7:0]         yPeak,
  output logic               objectFound,
  output logic               resultValid,
  output logic               busy
);

  localparam int CNT_W = $clog2(NUM_BINS) + 1;
  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(NUM_BINS);
  localparam logic [CNT_W-1:0]   LAST_BIN = CNT_W'(NUM_BINS - 1);
  localparam logic [COUNT_W-1:0] THRESH   = COUNT_W'(THRESHOLD);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQUEST  = 3'd1,
    COLLECT  = 3'd2,
    CLEAR    = 3'd3,
    WAIT_CLR = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t state_r, nextState_s;

  logic [CNT_W-1:0]   xCnt_r, yCnt_r;
  logic [7:0]         xMin_r, xMax_r, xPeak_r, yMin_r, yMax_r, yPeak_r;
  logic [COUNT_W-1:0] xPeakCnt_r, yPeakCnt_r;
  logic               xFound_r, yFound_r;
  logic               xAccept_s, yAccept_s, xDone_s, yDone_s, startScan_s;

  function automatic logic isOccupied(input logic [COUNT_W-1:0] count);
    return count >= THRESH;
  endfunction

  function automatic logic [7:0] binIndex(input logic [CNT_W-1:0] cnt);
    return 8'(cnt);
  endfunction

  // An axis is done once its counter reaches NUM_BINS, including the bin landing this cycle
  assign xAccept_s   = (state_r == COLLECT) && xValid && (xCnt_r != FULL_CNT);
  assign yAccept_s   = (state_r == COLLECT) && yValid && (yCnt_r != FULL_CNT);
  assign xDone_s     = (xCnt_r == FULL_CNT) || (xAccept_s && (xCnt_r == LAST_BIN));
  assign yDone_s     = (yCnt_r == FULL_CNT) || (yAccept_s && (yCnt_r == LAST_BIN));
  assign startScan_s = (state_r == IDLE) && (nextState_s == REQUEST);

  // Next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE:     if (enable && ready) nextState_s = REQUEST; else nextState_s = IDLE;
      REQUEST:  nextState_s = COLLECT;
      COLLECT:  if (xDone_s && yDone_s) nextState_s = CLEAR; else nextState_s = COLLECT;
      CLEAR:    nextState_s = WAIT_CLR;
      WAIT_CLR: if (histogramClear) nextState_s = DONE; else nextState_s = WAIT_CLR;
      DONE:     nextState_s = IDLE;
      default:  nextState_s = IDLE;
    endcase
  end

  // State register; strobes are registered from the next state so they align with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      readHistogram  <= 1'b0;
      clearHistogram <= 1'b0;
      resultValid    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_r        <= nextState_s;
      readHistogram  <= (nextState_s == REQUEST);
      clearHistogram <= (nextState_s == CLEAR);
      resultValid    <= (nextState_s == DONE);
      busy           <= (nextState_s != IDLE);
    end
  end

  // X axis scan accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xCnt_r <= '0; xMin_r <= 8'd0; xMax_r <= 8'd0; xPeak_r <= 8'd0;
      xPeakCnt_r <= '0; xFound_r <= 1'b0;
    end else if (startScan_s) begin
      xCnt_r <= '0; xMin_r <= 8'd0; xMax_r <= 8'd0; xPeak_r <= 8'd0;
      xPeakCnt_r <= '0; xFound_r <= 1'b0;
    end else if (xAccept_s) begin
      if (isOccupied(xHistogramOut)) begin
        if (!xFound_r) xMin_r <= binIndex(xCnt_r);
        xMax_r   <= binIndex(xCnt_r);
        xFound_r <= 1'b1;
      end
      // Strict compare keeps the lowest index on ties
      if (xHistogramOut > xPeakCnt_r) begin
        xPeakCnt_r <= xHistogramOut;
        xPeak_r    <= binIndex(xCnt_r);
      end
      xCnt_r <= xCnt_r + CNT_W'(1);
    end
  end

  // Y axis scan accumulator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      yCnt_r <= '0; yMin_r <= 8'd0; yMax_r <= 8'd0; yPeak_r <= 8'd0;
      yPeakCnt_r <= '0; yFound_r <= 1'b0;
    end else if (startScan_s) begin
      yCnt_r <= '0; yMin_r <= 8'd0; yMax_r <= 8'd0; yPeak_r <= 8'd0;
      yPeakCnt_r <= '0; yFound_r <= 1'b0;
    end else if (yAccept_s) begin
      if (isOccupied(yHistogramOut)) begin
        if (!yFound_r) yMin_r <= binIndex(yCnt_r);
        yMax_r   <= binIndex(yCnt_r);
        yFound_r <= 1'b1;
      end
      if (yHistogramOut > yPeakCnt_r) begin
        yPeakCnt_r <= yHistogramOut;
        yPeak_r    <= binIndex(yCnt_r);
      end
      yCnt_r <= yCnt_r + CNT_W'(1);
    end
  end

  // Result registers, loaded on entry to DONE and held until the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xMin <= 8'd0; xMax <= 8'd0; yMin <= 8'd0; yMax <= 8'd0;
      xPeak <= 8'd0; yPeak <= 8'd0; objectFound <= 1'b0;
    end else if (nextState_s == DONE) begin
      xMin        <= xFound_r ? xMin_r : 8'd0;
      xMax        <= xFound_r ? xMax_r : 8'd0;
      yMin        <= yFound_r ? yMin_r : 8'd0;
      yMax        <= yFound_r ? yMax_r : 8'd0;
      xPeak       <= xPeak_r;
      yPeak       <= yPeak_r;
      objectFound <= xFound_r && yFound_r;
    end
  end

endmodule

// File: tb/tb_histogram_object_locator.sv
// Directed bench for histogram_object_locator: two instances (THRESHOLD 1 and 4) share
// stimulus; expected results are queued per frame and checked on resultValid.
module tb_histogram_object_locator;

  localparam int NB = 256;

  typedef struct packed {
    logic [7:0] xMin, xMax, yMin, yMax, xPeak, yPeak;
    logic       found;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, ready, xValid, yValid, histogramClear;
  logic [7:0] xHistogramOut, yHistogramOut;

  logic       aRd, aClr, aRv, aBusy, aFound, bRd, bClr, bRv, bBusy, bFound;
  logic [7:0] aXMin, aXMax, aYMin, aYMax, aXPeak, aYPeak;
  logic [7:0] bXMin, bXMax, bYMin, bYMax, bXPeak, bYPeak;
  res_t       obsA, obsB;
  assign obsA = {aXMin, aXMax, aYMin, aYMax, aXPeak, aYPeak, aFound};
  assign obsB = {bXMin, bXMax, bYMin, bYMax, bXPeak, bYPeak, bFound};

  histogram_object_locator #(.NUM_BINS(NB), .COUNT_W(8), .THRESHOLD(1)) dutA (
    .clk(clk), .reset(reset), .enable(enable), .ready(ready), .readHistogram(aRd),
    .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut), .xValid(xValid),
    .yValid(yValid), .clearHistogram(aClr), .histogramClear(histogramClear),
    .xMin(aXMin), .xMax(aXMax), .yMin(aYMin), .yMax(aYMax), .xPeak(aXPeak), .yPeak(aYPeak),
    .objectFound(aFound), .resultValid(aRv), .busy(aBusy));

  histogram_object_locator #(.NUM_BINS(NB), .COUNT_W(8), .THRESHOLD(4)) dutB (
    .clk(clk), .reset(reset), .enable(enable), .ready(ready), .readHistogram(bRd),
    .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut), .xValid(xValid),
    .yValid(yValid), .clearHistogram(bClr), .histogramClear(histogramClear),
    .xMin(bXMin), .xMax(bXMax), .yMin(bYMin), .yMax(bYMax), .xPeak(bXPeak), .yPeak(bYPeak),
    .objectFound(bFound), .resultValid(bRv), .busy(bBusy));

  int cyc = 0, rdCnt = 0, clrCnt = 0, rvCnt = 0;
  int total = 0, bad = 0;
  logic [7:0] xBins [NB];
  logic [7:0] yBins [NB];
  res_t qA[$], qB[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters for the handshake strobes
  always @(negedge clk) begin
    if (aRd) rdCnt <= rdCnt + 1;
    if (aClr) clrCnt <= clrCnt + 1;
    if (aRv) rvCnt <= rvCnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: first/last occupied bin, and lowest index holding the maximum count
  function automatic logic [24:0] axisModel(input logic [7:0] b [NB], input int thr);
    logic found, hit;
    logic [7:0] mn, mx, pk;
    int maxVal;
    found = 1'b0; hit = 1'b0; mn = 8'd0; mx = 8'd0; pk = 8'd0; maxVal = 0;
    for (int i = 0; i < NB; i++)
      if (!found && int'(b[i]) >= thr) begin mn = 8'(i); found = 1'b1; end
    for (int i = NB - 1; i >= 0; i--)
      if (!hit && int'(b[i]) >= thr) begin mx = 8'(i); hit = 1'b1; end
    for (int i = 0; i < NB; i++)
      if (int'(b[i]) > maxVal) maxVal = int'(b[i]);
    hit = 1'b0;
    for (int i = 0; i < NB; i++)
      if (!hit && int'(b[i]) == maxVal) begin pk = 8'(i); hit = 1'b1; end
    return {found, mn, mx, pk};
  endfunction

  function automatic res_t model(input int thr);
    res_t r;
    logic [24:0] ax, ay;
    ax = axisModel(xBins, thr);
    ay = axisModel(yBins, thr);
    r.xMin = ax[16:9]; r.xMax = ax[8:1] ; r.xPeak = ax[7:0];
    r.xMin = ax[23:16]; r.xMax = ax[15:8]; r.xPeak = ax[7:0];
    r.yMin = ay[23:16]; r.yMax = ay[15:8]; r.yPeak = ay[7:0];
    r.found = ax[24] && ay[24];
    return r;
  endfunction

  task automatic clearBins();
    for (int i = 0; i < NB; i++) begin xBins[i] = 8'd0; yBins[i] = 8'd0; end
  endtask

  task automatic loadBlob();
    clearBins();
    for (int i = 40; i <= 60; i++) xBins[i] = 8'd5;
    xBins[50] = 8'd9;
    for (int i = 100; i <= 120; i++) yBins[i] = 8'd3;
    yBins[110] = 8'd7;
  endtask

  task automatic compareRes(input string dut, input res_t o, input res_t e);
    check({dut, "_xMin"}, 32'(o.xMin), 32'(e.xMin));
    check({dut, "_xMax"}, 32'(o.xMax), 32'(e.xMax));
    check({dut, "_yMin"}, 32'(o.yMin), 32'(e.yMin));
    check({dut, "_yMax"}, 32'(o.yMax), 32'(e.yMax));
    check({dut, "_xPeak"}, 32'(o.xPeak), 32'(e.xPeak));
    check({dut, "_yPeak"}, 32'(o.yPeak), 32'(e.yPeak));
    check({dut, "_objectFound"}, 32'(o.found), 32'(e.found));
  endtask

  task automatic startScan(output int c0);
    enable = 1'b1; ready = 1'b1; c0 = cyc;
    tick();
    check("readHistogram_cycle1", 32'(aRd), 32'd1);
    tick();
    check("readHistogram_single", 32'(aRd), 32'd0);
    enable = 1'b0;
  endtask

  task automatic streamConcurrent(input int nBins);
    for (int i = 0; i < nBins; i++) begin
      xValid = 1'b1; yValid = 1'b1; xHistogramOut = xBins[i]; yHistogramOut = yBins[i];
      tick();
    end
    xValid = 1'b0; yValid = 1'b0;
  endtask

  task automatic streamSkewed();
    for (int i = 0; i < NB; i++) begin
      yValid = 1'b1; yHistogramOut = yBins[i];
      tick();
      yValid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1) check("no_clear_before_last_x", 32'(aClr), 32'd0);
      xValid = 1'b1; xHistogramOut = xBins[i];
      yValid = (i % 17 == 0); yHistogramOut = 8'hFF;
      tick();
      xValid = 1'b0; yValid = 1'b0;
      if (i < NB - 1) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic finishScan(input int ackDelay, input int c0, input bit timeCheck, input int rvBase);
    check("clearHistogram_after_last_bin", 32'(aClr), 32'd1);
    ready = 1'b0;
    xValid = 1'b1; xHistogramOut = 8'hFF;
    tick();
    xValid = 1'b0;
    check("clearHistogram_single", 32'(aClr), 32'd0);
    repeat (ackDelay) tick();
    check("busy_waiting_ack", 32'(aBusy), 32'd1);
    check("no_result_before_ack", 32'(rvCnt - rvBase), 32'd0);
    histogramClear = 1'b1;
    tick();
    histogramClear = 1'b0;
    check("resultValid_after_ack", 32'(aRv), 32'd1);
    check("resultValid_after_ack_B", 32'(bRv), 32'd1);
    if (timeCheck) check("min_turnaround", 32'(cyc - c0), 32'(1 + NB + 3));
    check("scoreboard_A_depth", 32'(qA.size()), 32'd1);
    check("scoreboard_B_depth", 32'(qB.size()), 32'd1);
    if (qA.size() > 0) compareRes("A", obsA, qA.pop_front());
    if (qB.size() > 0) compareRes("B", obsB, qB.pop_front());
    tick();
    check("resultValid_one_cycle", 32'(aRv), 32'd0);
    check("busy_idle", 32'(aBusy), 32'd0);
  endtask

  task automatic runScan(input bit skewed, input int ackDelay, input bit timeCheck);
    int c0, rdBase, clrBase, rvBase;
    rdBase = rdCnt; clrBase = clrCnt; rvBase = rvCnt;
    qA.push_back(model(1));
    qB.push_back(model(4));
    startScan(c0);
    if (skewed) streamSkewed(); else streamConcurrent(NB);
    finishScan(ackDelay, c0, timeCheck, rvBase);
    check("readHistogram_pulses", 32'(rdCnt - rdBase), 32'd1);
    check("clearHistogram_pulses", 32'(clrCnt - clrBase), 32'd1);
    check("resultValid_pulses", 32'(rvCnt - rvBase), 32'd1);
  endtask

  initial begin
    int c0, clrBase;
    reset = 1'b0; enable = 1'b0; ready = 1'b0; xValid = 1'b0; yValid = 1'b0;
    histogramClear = 1'b0; xHistogramOut = 8'd0; yHistogramOut = 8'd0;
    repeat (3) tick();
    check("reset_readHistogram", 32'(aRd), 32'd0);
    check("reset_clearHistogram", 32'(aClr), 32'd0);
    check("reset_resultValid", 32'(aRv), 32'd0);
    check("reset_busy", 32'(aBusy), 32'd0);
    check("reset_results", 32'({obsA.xMin, obsA.xMax, obsA.yMin, obsA.found}), 32'd0);
    reset = 1'b1;
    tick();

    // ready alone must not start a scan
    ready = 1'b1;
    repeat (3) tick();
    check("no_start_without_enable", 32'(aRd), 32'd0);
    check("idle_without_enable", 32'(aBusy), 32'd0);
    ready = 1'b0;
    tick();

    loadBlob();
    runScan(1'b0, 0, 1'b1);

    clearBins();
    runScan(1'b0, 2, 1'b0);

    clearBins();
    xBins[10] = 8'd4; xBins[20] = 8'd9; xBins[30] = 8'd9; xBins[5] = 8'd3;
    yBins[7] = 8'd1;
    runScan(1'b0, 1, 1'b0);

    loadBlob();
    runScan(1'b1, 3, 1'b0);

    loadBlob();
    runScan(1'b0, 20, 1'b0);

    // Reset in the middle of COLLECT
    clearBins();
    for (int i = 0; i < NB; i++) begin xBins[i] = 8'(i); yBins[i] = 8'(255 - i); end
    clrBase = clrCnt;
    startScan(c0);
    streamConcurrent(100);
    #2 reset = 1'b0;
    #1;
    check("midreset_busy", 32'(aBusy), 32'd0);
    check("midreset_clearHistogram", 32'(aClr), 32'd0);
    check("midreset_xMax", 32'(aXMax), 32'd0);
    check("midreset_objectFound", 32'(aFound), 32'd0);
    check("midreset_B_xPeak", 32'(bXPeak), 32'd0);
    ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midreset_no_clear_issued", 32'(clrCnt - clrBase), 32'd0);

    loadBlob();
    runScan(1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/histogram_object_locator.md
# histogram_object_locator

Consumer stage placed directly downstream of the histogram top level. Once a frame's X/Y projection histograms are complete, it requests a readout, scans both bin streams, and extracts the occupied-span bounding box and the peak bin of each axis. It then clears the histogram for the next frame and presents the results with a one-cycle strobe.

## Interface
Parameters:
- NUM_BINS, 256: bins per axis; bin index equals arrival order (0 first).
- COUNT_W, 8: width of a bin count.
- THRESHOLD, 1: a bin is occupied when count >= THRESHOLD.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; all state and outputs go to reset values immediately.
- enable  in  1  when high, a new scan may start from IDLE.
- ready  in  1  histogram complete and readable (from histogram stage).
- readHistogram  out  1  one-cycle request that starts the bin readout.
- xHistogramOut  in  COUNT_W  X bin count, qualified by xValid.
- yHistogramOut  in  COUNT_W  Y bin count, qualified by yValid.
- xValid  in  1  one X bin present this cycle.
- yValid  in  1  one Y bin present this cycle.
- clearHistogram  out  1  one-cycle clear request.
- histogramClear  in  1  clear-complete acknowledge (level or pulse).
- xMin, xMax, yMin, yMax  out  8  first/last occupied bin per axis.
- xPeak, yPeak  out  8  index of maximum-count bin per axis.
- objectFound  out  1  at least one occupied bin on both axes.
- resultValid  out  1  one-cycle strobe; result outputs are stable from this cycle until the next strobe.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, REQUEST, COLLECT, CLEAR, WAIT_CLR, DONE.
- IDLE: when enable=1 and ready=1, go to REQUEST. Scan accumulators and bin counters are zeroed on entry to REQUEST.
- REQUEST: readHistogram=1 for exactly one cycle, then go to COLLECT.
- COLLECT: separate X and Y bin counters, each 0..NUM_BINS-1. X and Y streams are independent: they may be concurrent, interleaved, or gapped.
- On each xValid, the bin index is the X counter value. Occupancy and peak are evaluated, then the counter increments. Y is handled identically.
- Occupied bin handling: the first occupied bin sets min; every occupied bin sets max.
- Peak: count > running max updates the peak index. Ties keep the lower index. The running max starts at 0, so an all-zero axis gives peak 0.
- When both counters have received NUM_BINS bins, go to CLEAR. Valids beyond NUM_BINS on an axis are ignored.
- CLEAR: clearHistogram=1 for one cycle, then go to WAIT_CLR.
- WAIT_CLR: stay until histogramClear=1, then go to DONE.
- DONE: register results; resultValid=1 for one cycle; return to IDLE.
- If an axis has no occupied bin, objectFound=0 and that axis's min and max are 0. Peak is still reported.
- enable is sampled only in IDLE. Deasserting enable mid-scan does not abort the scan.
- A held-high ready after DONE restarts a scan only if enable=1. The upstream stage drops ready on clear.

## Timing
- Reset values: readHistogram=0, clearHistogram=0, resultValid=0, busy=0, objectFound=0, all 8-bit results=0, state=IDLE.
- Cycle 0: ready=enable=1 sampled in IDLE.
- Cycle 1: readHistogram=1.
- X/Y data may arrive from cycle 2 onward.
- Last bin sampled at cycle N → clearHistogram=1 at N+1.
- histogramClear sampled high at cycle M → resultValid=1 at M+1. Results update in that same cycle.
- Minimum turnaround with back-to-back concurrent streams and an immediate ack: 1 + NUM_BINS + 3 cycles.
- The peak compare is unsigned COUNT_W-bit. Bin counters are log2(NUM_BINS)+1 bits wide so that the count NUM_BINS is detectable.
- Reset asserted mid-scan: returns to IDLE with no clear issued. Results are zeroed.

## Test plan
- Single blob: X bins 40..60 = 5 with bin 50 = 9; Y bins 100..120 = 3 with bin 110 = 7; streams concurrent → xMin=40, xMax=60, xPeak=50, yMin=100, yMax=120, yPeak=110, objectFound=1. readHistogram and clearHistogram each pulse once.
- Empty frame: all counts 0 → objectFound=0; all results 0; resultValid pulses once.
- Tie and threshold (THRESHOLD=4): X bin 10=4, bin 20=9, bin 30=9, bin 5=3 → xMin=10, xMax=30, xPeak=20 (bin 5 is ignored).
- Streams skewed and gapped: all 256 Y bins sent before any X bin, with random gaps; extra xValid after 256 bins → identical results to the concurrent case; clearHistogram issued only after the 256th X bin.
- Delayed ack: histogramClear held low for 20 cycles → resultValid exactly 1 cycle after the ack.
- Reset mid-COLLECT at bin 100, then ready/enable reasserted → no clearHistogram pulse before reset; clean full scan afterward.
